// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron fed by 8-bit signed synapse weights.
// Spikes leave on a valid/ack handshake and are followed by a refractory period.
module lif_neuron #(
  parameter int POT_W         = 16,
  parameter int THRESHOLD     = 200,
  parameter int LEAK_SHIFT    = 3,
  parameter int V_RESET       = 0,
  parameter int REFRACT_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic [7:0]       weight_in,
  input  logic             weight_valid,
  output logic             weight_ready,
  input  logic             tick,
  output logic             spike_valid,
  input  logic             spike_ack,
  output logic [POT_W-1:0] potential,
  output logic [15:0]      spike_count,
  output logic [1:0]       state_out
);

  localparam logic [1:0] S_INT  = 2'd0;
  localparam logic [1:0] S_LEAK = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_REFR = 2'd3;

  localparam int RW = (REFRACT_TICKS > 1) ? $clog2(REFRACT_TICKS + 1) : 1;

  localparam logic signed [POT_W:0]   P_MAX = {2'b00, {(POT_W-1){1'b1}}};
  localparam logic signed [POT_W-1:0] THR   = POT_W'(THRESHOLD);
  localparam logic [POT_W-1:0]        VRST  = POT_W'(V_RESET);
  localparam logic [RW-1:0]           R_INI = RW'(REFRACT_TICKS);

  logic [1:0]       state_q, state_d;
  logic [POT_W-1:0] pot_q, pot_d;
  logic             sv_q, sv_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [RW-1:0]    ref_q, ref_d;
  logic             pend_q, pend_d;

  logic                    accept;
  logic                    tick_any;
  logic                    ack_ok;
  logic                    fire;
  logic signed [POT_W:0]   sum;
  logic signed [POT_W-1:0] leak_v;
  logic [POT_W-1:0]        sum_sat;

  assign weight_ready = (state_q == S_INT) || (state_q == S_REFR);
  assign accept       = weight_valid && weight_ready;
  assign tick_any     = tick || pend_q;
  assign ack_ok       = spike_ack && sv_q;

  assign sum    = $signed({1'b0, pot_q})
                + $signed({{(POT_W-7){weight_in[7]}}, weight_in});
  assign leak_v = $signed(pot_q) - ($signed(pot_q) >>> LEAK_SHIFT);
  assign fire   = leak_v >= THR;

  // Potential lives in [0, 2^(POT_W-1)-1]; the extra sum bit catches both ends.
  always_comb begin
    sum_sat = sum[POT_W-1:0];
    if (sum < 0)
      sum_sat = '0;
    else if (sum > P_MAX)
      sum_sat = P_MAX[POT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INT;
      pot_q   <= '0;
      sv_q    <= 1'b0;
      cnt_q   <= '0;
      ref_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pot_q   <= pot_d;
      sv_q    <= sv_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_INT;
    end else begin
      unique case (state_q)
        S_INT:   if (tick_any) state_d = S_LEAK;
        S_LEAK:  state_d = fire ? S_FIRE : S_INT;
        S_FIRE:  if (ack_ok)
                   state_d = (REFRACT_TICKS == 0) ? S_INT : S_REFR;
        S_REFR:  if (tick_any && ref_q <= RW'(1)) state_d = S_INT;
        default: state_d = S_INT;
      endcase
    end
  end

  always_comb begin
    pot_d  = pot_q;
    sv_d   = sv_q;
    cnt_d  = cnt_q;
    ref_d  = ref_q;
    pend_d = pend_q;
    if (kill) begin
      pot_d  = '0;
      sv_d   = 1'b0;
      cnt_d  = '0;
      ref_d  = '0;
      pend_d = 1'b0;
    end else begin
      unique case (state_q)
        S_INT: begin
          if (accept)   pot_d  = sum_sat;
          if (tick_any) pend_d = 1'b0;
        end
        S_LEAK: begin
          pend_d = tick;
          if (fire) begin
            pot_d = VRST;
            sv_d  = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end else begin
            pot_d = leak_v;
          end
        end
        S_FIRE: begin
          if (tick) pend_d = 1'b1;
          if (ack_ok) begin
            sv_d  = 1'b0;
            ref_d = R_INI;
          end
        end
        S_REFR: begin
          // Weights accepted here are dropped on purpose.
          if (tick_any) begin
            pend_d = 1'b0;
            if (ref_q != '0) ref_d = ref_q - RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign potential   = pot_q;
  assign spike_valid = sv_q;
  assign spike_count = cnt_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: directed scenarios then random traffic,
// all compared against an integer reference model each cycle.
module tb_lif_neuron;

  localparam int THR  = 200;
  localparam int SH   = 3;
  localparam int REF  = 2;
  localparam int PMAX = 32767;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        kill = 1'b0;
  logic [7:0]  weight_in = '0;
  logic        weight_valid = 1'b0;
  logic        weight_ready;
  logic        tick = 1'b0;
  logic        spike_valid;
  logic        spike_ack = 1'b0;
  logic [15:0] potential;
  logic [15:0] spike_count;
  logic [1:0]  state_out;

  int n_checks = 0;
  int n_err = 0;

  // reference model: mode 0 integrate, 1 leak, 2 fire, 3 refract
  int m_pot, m_sv, m_cnt, m_st, m_ref, m_pend;

  lif_neuron dut (
    .clk         (clk),
    .rst         (rst),
    .kill        (kill),
    .weight_in   (weight_in),
    .weight_valid(weight_valid),
    .weight_ready(weight_ready),
    .tick        (tick),
    .spike_valid (spike_valid),
    .spike_ack   (spike_ack),
    .potential   (potential),
    .spike_count (spike_count),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pot = 0; m_sv = 0; m_cnt = 0;
    m_st = 0; m_ref = 0; m_pend = 0;
  endtask

  task automatic model(bit wv, int w, bit tk, bit ack, bit kl);
    int s;
    int lv;
    if (kl) begin
      model_reset();
      return;
    end
    case (m_st)
      0: begin
        if (wv) begin
          s = m_pot + w;
          m_pot = (s < 0) ? 0 : (s > PMAX) ? PMAX : s;
        end
        if (tk || m_pend != 0) begin
          m_st = 1;
          m_pend = 0;
        end
      end
      1: begin
        lv = m_pot - m_pot / (1 << SH);
        m_pend = tk;
        if (lv >= THR) begin
          m_pot = 0;
          m_sv = 1;
          m_st = 2;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_pot = lv;
          m_st = 0;
        end
      end
      2: begin
        if (tk) m_pend = 1;
        if (ack) begin
          m_sv = 0;
          m_ref = REF;
          m_st = (REF == 0) ? 0 : 3;
        end
      end
      default: begin
        if (tk || m_pend != 0) begin
          m_pend = 0;
          m_ref--;
          if (m_ref <= 0) m_st = 0;
        end
      end
    endcase
  endtask

  task automatic check_all(string tag);
    chk({tag, ".potential"}, potential, m_pot);
    chk({tag, ".spike_valid"}, spike_valid, m_sv);
    chk({tag, ".spike_count"}, spike_count, m_cnt);
    chk({tag, ".state_out"}, state_out, m_st);
  endtask

  task automatic step(string tag, bit wv, int w, bit tk, bit ack, bit kl);
    weight_valid = wv;
    weight_in    = 8'(w);
    tick         = tk;
    spike_ack    = ack;
    kill         = kl;
    chk({tag, ".weight_ready"}, weight_ready, (m_st == 0 || m_st == 3));
    model(wv, w, tk, ack, kl);
    @(posedge clk);
    #1;
    weight_valid = 1'b0;
    tick         = 1'b0;
    spike_ack    = 1'b0;
    kill         = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic go_fire(string tag);
    step(tag, 1, 127, 0, 0, 0);
    step(tag, 1, 127, 0, 0, 0);
    step(tag, 0, 0, 1, 0, 0);
    idle(tag, 1);
  endtask

  initial begin
    int w;
    model_reset();
    #12;
    chk("reset.potential", potential, 0);
    chk("reset.spike_valid", spike_valid, 0);
    chk("reset.spike_count", spike_count, 0);
    chk("reset.state_out", state_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    step("t1", 1, 100, 0, 0, 0);
    step("t1", 1, 100, 0, 0, 0);
    step("t1", 1, 50, 0, 0, 0);
    step("t1_tick", 0, 0, 1, 0, 0);
    chk("t1_leak_state", state_out, 1);
    chk("t1_leak_sv", spike_valid, 0);
    idle("t1_fire", 1);
    chk("t1_fire_sv", spike_valid, 1);
    chk("t1_fire_pot", potential, 0);
    chk("t1_fire_cnt", spike_count, 1);
    idle("t1_hold", 5);
    chk("t1_hold_sv", spike_valid, 1);
    step("t1_ack", 0, 0, 0, 1, 0);
    chk("t1_refr_state", state_out, 3);

    for (int i = 0; i < 3; i++) step("t4_drop", 1, 127, 0, 0, 0);
    chk("t4_drop_pot", potential, 0);
    step("t4_tick1", 0, 0, 1, 0, 0);
    idle("t4", 1);
    step("t4_tick2", 0, 0, 1, 0, 0);
    chk("t4_back_state", state_out, 0);
    step("t4_w10", 1, 10, 0, 0, 0);
    chk("t4_w10_pot", potential, 10);

    step("t2_kill", 0, 0, 0, 0, 1);
    step("t2", 1, 100, 0, 0, 0);
    step("t2", 1, 100, 0, 0, 0);
    step("t2_tick", 0, 0, 1, 0, 0);
    idle("t2", 1);
    chk("t2_leak1", potential, 175);
    step("t2_tick2", 0, 0, 1, 0, 0);
    idle("t2", 1);
    chk("t2_leak2", potential, 154);
    chk("t2_nospike", spike_valid, 0);

    step("t3_kill", 0, 0, 0, 0, 1);
    step("t3", 1, 20, 0, 0, 0);
    step("t3_clamp", 1, -50, 0, 0, 0);
    chk("t3_clamp_pot", potential, 0);
    for (int i = 0; i < 300; i++) step("t3_sat", 1, 127, 0, 0, 0);
    chk("t3_sat_pot", potential, PMAX);

    step("t5_kill", 0, 0, 0, 0, 1);
    step("t5_same", 1, 5, 1, 0, 0);
    idle("t5", 1);
    chk("t5_same_pot", potential, 5);
    go_fire("t5_fire");
    step("t5_tickfire", 0, 0, 1, 0, 0);
    step("t5_ack", 0, 0, 0, 1, 0);
    idle("t5_pend", 1);
    chk("t5_pend_state", state_out, 3);
    step("t5_tick", 0, 0, 1, 0, 0);
    chk("t5_done_state", state_out, 0);

    go_fire("t6_fire");
    chk("t6_fire_sv", spike_valid, 1);
    step("t6_kill", 0, 0, 0, 0, 1);
    chk("t6_kill_sv", spike_valid, 0);
    chk("t6_kill_cnt", spike_count, 0);
    idle("t6_after_kill", 4);

    go_fire("t6_fire2");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6_rst.potential", potential, 0);
    chk("t6_rst.spike_valid", spike_valid, 0);
    chk("t6_rst.spike_count", spike_count, 0);
    chk("t6_rst.state_out", state_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle("t6_after_rst", 4);

    for (int i = 0; i < 3000; i++) begin
      w = int'($urandom_range(0, 200)) - 70;
      if (w > 127) w = 127;
      step("rnd", 1'($urandom_range(0, 1)), w,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Leaky integrate-and-fire neuron directly downstream of the synapse weight table; consumes the 8-bit signed weights it reads out.
- Accumulates weights into a membrane potential, applies a shift-based leak on each timestep tick, and fires when the threshold is crossed.
- Emits a spike through a valid/ack handshake, then enforces a refractory period counted in ticks.

Parameters:
POT_W, 16, membrane potential width, signed two's complement
THRESHOLD, 200, firing threshold; fire when potential after leak >= THRESHOLD
LEAK_SHIFT, 3, leak amount = potential >>> LEAK_SHIFT (arithmetic shift)
V_RESET, 0, potential loaded on fire
REFRACT_TICKS, 2, number of ticks spent in REFRACT after a spike is acknowledged

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
kill  input  1  synchronous clear of neuron state, active high
weight_in  input  8  signed weight from the synapse weight table
weight_valid  input  1  weight_in is valid this cycle
weight_ready  output  1  neuron accepts a weight this cycle
tick  input  1  single-cycle timestep boundary pulse
spike_valid  output  1  spike pending; held until acknowledged
spike_ack  input  1  downstream consumed the spike
potential  output  POT_W  current membrane potential, for debug and verification
spike_count  output  16  spikes fired since reset or kill; saturates at 65535
state_out  output  2  state encoding: 0 INTEGRATE, 1 LEAK, 2 FIRE, 3 REFRACT

Behaviour:
- Reset (rst low, asynchronous): state INTEGRATE, potential 0, spike_valid 0, spike_count 0, refractory counter 0, tick_pending 0.
- weight_ready = 1 in INTEGRATE and REFRACT, 0 in LEAK and FIRE. A weight is accepted only when weight_valid && weight_ready.
- INTEGRATE:
  - Accepted weight is sign-extended to POT_W and added to potential.
  - The sum saturates high at 2^(POT_W-1)-1 and clamps low at 0; potential is never negative.
  - tick (or tick_pending) moves the block to LEAK next cycle. A weight accepted in the same cycle as the tick is added before the leak.
- LEAK (exactly one cycle):
  - L = potential - (potential >>> LEAK_SHIFT).
  - If L >= THRESHOLD: potential <= V_RESET, state FIRE, spike_valid <= 1, spike_count increments (saturating).
  - Otherwise potential <= L and state INTEGRATE.
  - Clears tick_pending.
- Latency: tick sampled in cycle N, LEAK in cycle N+1, spike_valid high from cycle N+2.
- FIRE: spike_valid held high until spike_ack is sampled high. spike_ack with spike_valid high clears spike_valid next cycle; state REFRACT, refractory counter <= REFRACT_TICKS. spike_ack while spike_valid is low is ignored.
- REFRACT:
  - Accepted weights are dropped; the handshake completes with no effect on potential.
  - Each tick decrements the counter. The tick that brings the counter to 0 returns the block to INTEGRATE, with no leak applied for that tick.
  - If REFRACT_TICKS = 0, FIRE goes straight to INTEGRATE on ack.
- tick arriving in LEAK or FIRE sets tick_pending (one deep; further ticks are lost).
  - tick_pending is consumed by INTEGRATE (triggers LEAK) or by REFRACT (counts as a refractory tick) on the next cycle in that state.
- kill (synchronous) has priority over everything except rst: potential 0, spike_valid 0, spike_count 0, tick_pending 0, state INTEGRATE. kill during FIRE drops the pending spike.
- rst asserted mid-FIRE or mid-REFRACT returns all outputs to their reset values immediately; no spike is emitted after reset releases.
- Output timing: all outputs are registered except weight_ready, which is decoded from state.

Test Plan:
1. Fire path: weights 100, 100, 50 accepted, then tick → LEAK gives 250 - 31 = 219 ≥ 200; spike_valid rises 2 cycles after tick; potential 0; spike_count 1. Hold spike_ack low for 5 cycles → spike_valid stays high; ack → REFRACT.
2. Sub-threshold leak: weights 100, 100, then tick → potential 175, no spike; a second tick → 175 - 21 = 154, still no spike.
3. Clamp and saturation: weight -50 from potential 20 → 0. Then 300 weights of 127 → potential 32767, never wraps negative.
4. Refractory (REFRACT_TICKS = 2): after ack, send weights 127 ×3 and 2 ticks → potential stays 0 and weight_ready stays high. Back in INTEGRATE after the 2nd tick; the next weight 10 → potential 10.
5. Simultaneous events: weight 5 and tick in the same INTEGRATE cycle → potential 5 - 0 = 5. A tick during FIRE is captured by tick_pending and consumed as the first refractory tick.
6. kill or rst in FIRE with spike_valid high → spike_valid 0, potential 0, spike_count 0, state_out 0 (rst immediately, kill next edge); no spike afterwards.
